// File: rtl/sync_pkg.sv
// Shared encodings and helpers for the multi-channel synchroniser / edge detector.
package sync_pkg;

   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] EDGE_OFF  = 2'b00;
   localparam logic [MODE_W-1:0] EDGE_RISE = 2'b01;
   localparam logic [MODE_W-1:0] EDGE_FALL = 2'b10;
   localparam logic [MODE_W-1:0] EDGE_BOTH = 2'b11;

   // Bit 0 of the mode enables rising updates, bit 1 enables falling updates.
   function automatic logic edge_enabled(input logic [MODE_W-1:0] mode, input logic rising);
      return rising ? mode[0] : mode[1];
   endfunction

endpackage

// File: rtl/sync_edge_ch.sv
// One channel: synchroniser chain, optional stability filter, edge pulse and sticky flag.
module sync_edge_ch
   import sync_pkg::*;
#(
   parameter int unsigned STAGES = 2,
   parameter int unsigned FILT   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_d,
   input  logic [MODE_W-1:0] i_mode,
   input  logic              i_ev_clr,
   output logic              o_q,
   output logic              o_p,
   output logic              o_ev,
   output logic              o_p_next_c
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

   logic r_q;
   logic r_p;
   logic r_ev;
   logic w_s;
   logic w_upd;
   logic w_p_next;

   // Plain shift chain; nothing may sit between stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign w_s = r_sync[STAGES-1];

   if (FILT <= 1) begin : g_bypass
      assign w_upd = w_s ^ r_q;
   end else begin : g_filt
      localparam int unsigned      CNT_W    = $clog2(FILT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

      logic [CNT_W-1:0] r_cnt;

      assign w_upd = (w_s != r_q) && (r_cnt == CNT_LAST);

      // Any cycle of agreement restarts the count, so short pulses are dropped.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt <= '0;
         end else if ((w_s == r_q) || w_upd) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // The new level (w_s) decides the edge direction; mode only matters on updates.
   assign w_p_next = w_upd & edge_enabled(i_mode, w_s);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q  <= 1'b0;
         r_p  <= 1'b0;
         r_ev <= 1'b0;
      end else begin
         if (w_upd) begin
            r_q <= w_s;
         end
         r_p  <= w_p_next;
         r_ev <= (r_ev & ~i_ev_clr) | w_p_next;
      end
   end

   assign o_q        = r_q;
   assign o_p        = r_p;
   assign o_ev       = r_ev;
   assign o_p_next_c = w_p_next;

endmodule

// File: rtl/sync_edge_multi.sv
// CH-channel synchroniser and edge detector with a registered any-pulse summary.
module sync_edge_multi
   import sync_pkg::*;
#(
   parameter int unsigned CH     = 4,
   parameter int unsigned STAGES = 2,
   parameter int unsigned FILT   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH-1:0]        d,
   input  logic [MODE_W*CH-1:0] mode,
   input  logic [CH-1:0]        ev_clr,
   output logic [CH-1:0]        q,
   output logic [CH-1:0]        p,
   output logic [CH-1:0]        ev,
   output logic                 any_p
);

   logic [CH-1:0] w_p_next;
   logic          r_any_p;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      sync_edge_ch #(
         .STAGES (STAGES),
         .FILT   (FILT)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .i_d        (d[i]),
         .i_mode     (mode[MODE_W*i +: MODE_W]),
         .i_ev_clr   (ev_clr[i]),
         .o_q        (q[i]),
         .o_p        (p[i]),
         .o_ev       (ev[i]),
         .o_p_next_c (w_p_next[i])
      );
   end

   // Built from the per-channel next-pulse terms so it lines up with p.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_any_p <= 1'b0;
      end else begin
         r_any_p <= |w_p_next;
      end
   end

   assign any_p = r_any_p;

endmodule

// File: doc/sync_edge_multi.md
# sync_edge_multi

Parametrised multi-channel synchroniser and edge detector. Brings CH asynchronous single-bit inputs into the `clk` domain through a configurable-depth flop chain, optionally applies a stability (glitch) filter, and produces a clean level, a one-cycle edge pulse per channel with runtime-selectable edge polarity, and sticky event flags. It replaces the fixed two-stage, rising/falling-agnostic pulse generator wherever the design crosses more than one control/status bit into the core clock domain.

## Interface
- `CH`, 4, number of independent channels (≥1)
- `STAGES`, 2, synchroniser depth (≥2); every stage carries the ASYNC_REG attribute
- `FILT`, 0, stability filter length in cycles; 0 or 1 = bypass, F≥2 = level must be stable F consecutive cycles

- `clk` input 1 — single clock
- `rst` input 1 — asynchronous, active-high reset
- `d` input CH — asynchronous inputs
- `mode` input 2·CH — per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- `ev_clr` input CH — per-channel sticky flag clear, synchronous
- `q` output CH — synchronised, filtered level
- `p` output CH — one-cycle edge pulse, registered
- `ev` output CH — sticky event flags
- `any_p` output 1 — OR of `p`, registered

## Operation
- Reset (async assert, sync deassert handled upstream): all sync stages, `q`, `p`, `ev`, `any_p`, and filter counters = 0.
- Sync chain: s[0] <= d; s[k] <= s[k-1]; `s = s[STAGES-1]`.
- Filter, per channel, counter `cnt` of width $clog2(FILT+1):
  - s == q: cnt <= 0.
  - s != q and (FILT ≤ 1 or cnt == FILT-1): q <= s, cnt <= 0, update event `upd` = 1.
  - else cnt <= cnt + 1.
- A mismatch interrupted by even one cycle of s == q restarts the count (pulses shorter than FILT cycles are discarded).
- Edge pulse: p[i] <= upd & (rising ? mode[2i] : mode[2i+1]); rising = new q is 1. `p` is high exactly on the first cycle `q` shows its new value.
- `mode` is sampled only on the update cycle; changing it never affects `q`, `cnt` or pending filtering.
- Sticky: ev[i] <= (ev[i] & ~ev_clr[i]) | p_next[i]; simultaneous set and clear → set wins (no lost event).
- `any_p` <= |p_next.
- Input already high when `rst` releases: treated as a rising edge after normal latency (`p` fires if rise enabled).

## Timing
- Input change settled before clock edge 1: s changes at edge STAGES.
- `q`/`p` change at edge STAGES+1 (FILT ≤ 1) or STAGES+FILT (FILT ≥ 2).
- Default (STAGES=2, FILT=0): 3-cycle latency, matching the existing pulse generator's level output.
- `p` width exactly one cycle; consecutive opposite edges at filtered rate produce separate pulses with no merge.
- Minimum accepted input pulse width: FILT cycles at the sync output (1 cycle when bypassed); narrower inputs may be lost by the synchroniser — by design.
- `ev` reflects a pulse in the same cycle as `p`; clear takes effect the following edge.

## Structure
- Shared package `sync_pkg`: mode encodings `EDGE_OFF`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH` (2-bit constants).
- Sub-module `sync_edge_ch`: one channel (sync chain, filter, pulse, sticky); top instantiates CH copies in a generate loop and builds `any_p`.
- No logic may sit between sync stages; `cnt` logic omitted by generate when FILT ≤ 1.

## Test plan
- Defaults, mode=01 on ch0, d[0] 0→1 before edge 1 → q[0]=1 and p[0]=1 at edge 3, p[0]=0 at edge 4, ev[0]=1 held.
- FILT=4, STAGES=3, d[1] high-pulse 3 cycles wide → q[1], p[1] stay 0; 6-cycle pulse → q[1] rises at edge 7, falls 4 cycles after s falls.
- mode=10 on ch2, toggle 0→1→0 (10-cycle gaps) → single p[2] on falling edge only; mode=11 → two pulses; mode=00 → none, q still tracks.
- ev_clr[3] asserted in the same cycle p[3] fires → ev[3] remains 1; clear next cycle with no event → ev[3]=0.
- rst asserted mid-filter (cnt=2, FILT=4) → all outputs 0 immediately; with d held high after release → rising pulse at nominal latency.
- All CH channels toggling on the same edge, all mode=11 → all p bits and any_p high same cycle; channels independent when toggled on different edges.
